// File: rtl/mp_arith_pkg.sv
// ---------------------------------------------------------------------------
// mp_arith_pkg
// Shared definitions for the multi-precision arithmetic sharing units:
//   - state_t   : sequencer state encodings (3-bit)
//   - OWNER_0/1 : requester identifiers
//   - DEFAULT_OPERAND_WIDTH / DEFAULT_TIMEOUT_CYCLES : parameter defaults
// ---------------------------------------------------------------------------
package mp_arith_pkg;

  localparam int DEFAULT_OPERAND_WIDTH  = 512;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ABORT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mp_adder_arbiter_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-way round-robin grant. A lone request always wins; when
// both request, the one that did not own the unit last time wins.
// Ports:
//   iReq0, iReq1  in   request lines
//   iLastOwner    in   owner of the most recently completed operation
//   oWinner       out  selected requester (OWNER_0 / OWNER_1)
//   oValid        out  at least one request present; oWinner is meaningful
// ---------------------------------------------------------------------------
module rr_arbiter_2
  import mp_arith_pkg::*;
(
  input  logic iReq0,
  input  logic iReq1,
  input  logic iLastOwner,
  output logic oWinner,
  output logic oValid
);

  always_comb begin
    oValid  = iReq0 | iReq1;
    oWinner = OWNER_0;
    if (iReq0 && iReq1) begin
      oWinner = (iLastOwner == OWNER_0) ? OWNER_1 : OWNER_0;
    end else if (iReq1) begin
      oWinner = OWNER_1;
    end
  end

endmodule

// File: rtl/mp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// mp_adder_arbiter
// Shares one multi-precision adder core between two requesters. Grants with
// round-robin fairness, latches the winner's operands, pulses the core start,
// waits for done (with a watchdog that aborts and resets the core) and hands
// the result plus a done/err pulse back to the owner. All outputs registered.
// Ports:
//   iClk, iRst            clock, asynchronous active-high reset
//   iReq0/1               level requests
//   iOpA0/iOpB0, iOpA1/iOpB1  requester operands, sampled on grant only
//   oAck0/1               one-cycle grant pulse
//   oDone0/1, oErr0/1     one-cycle completion / timeout-error pulse to owner
//   oRes                  last completed result (held)
//   oBusy                 high whenever not IDLE
//   oAddStart, oAddOpA/B, oAddRst  core control and latched operands
//   iAddRes, iAddDone     core result and done pulse
// ---------------------------------------------------------------------------
module mp_adder_arbiter
  import mp_arith_pkg::*;
#(
  parameter int OPERAND_WIDTH  = DEFAULT_OPERAND_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iReq0,
  input  logic                     iReq1,
  input  logic [OPERAND_WIDTH-1:0] iOpA0,
  input  logic [OPERAND_WIDTH-1:0] iOpB0,
  input  logic [OPERAND_WIDTH-1:0] iOpA1,
  input  logic [OPERAND_WIDTH-1:0] iOpB1,
  output logic                     oAck0,
  output logic                     oAck1,
  output logic                     oDone0,
  output logic                     oDone1,
  output logic                     oErr0,
  output logic                     oErr1,
  output logic [OPERAND_WIDTH:0]   oRes,
  output logic                     oBusy,
  output logic                     oAddStart,
  output logic [OPERAND_WIDTH-1:0] oAddOpA,
  output logic [OPERAND_WIDTH-1:0] oAddOpB,
  output logic                     oAddRst,
  input  logic [OPERAND_WIDTH:0]   iAddRes,
  input  logic                     iAddDone
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                   stateReg, stateNext;
  logic                     ownerReg, ownerNext;
  logic                     lastOwnerReg, lastOwnerNext;
  logic                     errReg, errNext;
  logic [CNT_W-1:0]         cntReg, cntNext;
  logic [OPERAND_WIDTH-1:0] opAReg, opANext;
  logic [OPERAND_WIDTH-1:0] opBReg, opBNext;
  logic [OPERAND_WIDTH:0]   resReg, resNext;
  logic [1:0]               ackReg, ackNext;
  logic [1:0]               doneReg, doneNext;
  logic [1:0]               errOutReg, errOutNext;
  logic                     busyReg, busyNext;
  logic                     startReg, startNext;
  logic                     addRstReg, addRstNext;

  logic                     grantWinner;
  logic                     grantValid;
  logic [1:0]               ownerHot;

  rr_arbiter_2 uArb (
    .iReq0      (iReq0),
    .iReq1      (iReq1),
    .iLastOwner (lastOwnerReg),
    .oWinner    (grantWinner),
    .oValid     (grantValid)
  );

  // One-hot view of the current owner, used to steer done/err pulses.
  for (genvar gi = 0; gi < 2; gi++) begin : gOwnerHot
    assign ownerHot[gi] = (ownerReg == 1'(gi));
  end

  always_comb begin
    stateNext     = stateReg;
    ownerNext     = ownerReg;
    lastOwnerNext = lastOwnerReg;
    errNext       = errReg;
    cntNext       = cntReg;
    opANext       = opAReg;
    opBNext       = opBReg;
    resNext       = resReg;
    ackNext       = 2'b00;
    doneNext      = 2'b00;
    errOutNext    = 2'b00;
    startNext     = 1'b0;
    addRstNext    = 1'b0;

    case (stateReg)
      S_IDLE: begin
        if (grantValid) begin
          opANext   = (grantWinner == OWNER_1) ? iOpA1 : iOpA0;
          opBNext   = (grantWinner == OWNER_1) ? iOpB1 : iOpB0;
          ownerNext = grantWinner;
          ackNext   = {grantWinner, ~grantWinner};
          // Start is raised on the same edge as the ack so that it is
          // visible while the sequencer sits in ISSUE.
          startNext = 1'b1;
          cntNext   = '0;
          stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cntNext   = '0;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        cntNext = cntReg + 1'b1;
        // Done takes priority over the watchdog on the final WAIT cycle.
        if (iAddDone) begin
          resNext   = iAddRes;
          errNext   = 1'b0;
          stateNext = S_RESP;
        end else if (cntReg == CNT_LAST) begin
          errNext    = 1'b1;
          addRstNext = 1'b1;
          stateNext  = S_ABORT;
        end
      end
      S_ABORT: begin
        errNext   = 1'b1;
        stateNext = S_RESP;
      end
      S_RESP: begin
        doneNext      = ownerHot;
        errOutNext    = errReg ? ownerHot : 2'b00;
        lastOwnerNext = ownerReg;
        stateNext     = S_IDLE;
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase

    busyNext = (stateNext != S_IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateReg     <= S_IDLE;
      ownerReg     <= OWNER_0;
      lastOwnerReg <= OWNER_1;
      errReg       <= 1'b0;
      cntReg       <= '0;
      opAReg       <= '0;
      opBReg       <= '0;
      resReg       <= '0;
      ackReg       <= 2'b00;
      doneReg      <= 2'b00;
      errOutReg    <= 2'b00;
      busyReg      <= 1'b0;
      startReg     <= 1'b0;
      addRstReg    <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      ownerReg     <= ownerNext;
      lastOwnerReg <= lastOwnerNext;
      errReg       <= errNext;
      cntReg       <= cntNext;
      opAReg       <= opANext;
      opBReg       <= opBNext;
      resReg       <= resNext;
      ackReg       <= ackNext;
      doneReg      <= doneNext;
      errOutReg    <= errOutNext;
      busyReg      <= busyNext;
      startReg     <= startNext;
      addRstReg    <= addRstNext;
    end
  end

  assign oAck0     = ackReg[0];
  assign oAck1     = ackReg[1];
  assign oDone0    = doneReg[0];
  assign oDone1    = doneReg[1];
  assign oErr0     = errOutReg[0];
  assign oErr1     = errOutReg[1];
  assign oRes      = resReg;
  assign oBusy     = busyReg;
  assign oAddStart = startReg;
  assign oAddOpA   = opAReg;
  assign oAddOpB   = opBReg;
  assign oAddRst   = addRstReg;

endmodule

// File: tb/tb_mp_adder_arbiter.sv
module tb_mp_adder_arbiter;

  localparam int W = 512;
  localparam int T = 64;

  logic         iClk;
  logic         iRst;
  logic         iReq0, iReq1;
  logic [W-1:0] iOpA0, iOpB0, iOpA1, iOpB1;
  logic         oAck0, oAck1, oDone0, oDone1, oErr0, oErr1;
  logic [W:0]   oRes;
  logic         oBusy, oAddStart, oAddRst;
  logic [W-1:0] oAddOpA, oAddOpB;
  logic [W:0]   iAddRes;
  logic         iAddDone;

  mp_adder_arbiter #(.OPERAND_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReq0(iReq0), .iReq1(iReq1),
    .iOpA0(iOpA0), .iOpB0(iOpB0), .iOpA1(iOpA1), .iOpB1(iOpB1),
    .oAck0(oAck0), .oAck1(oAck1), .oDone0(oDone0), .oDone1(oDone1),
    .oErr0(oErr0), .oErr1(oErr1), .oRes(oRes), .oBusy(oBusy),
    .oAddStart(oAddStart), .oAddOpA(oAddOpA), .oAddOpB(oAddOpB),
    .oAddRst(oAddRst), .iAddRes(iAddRes), .iAddDone(iAddDone)
  );

  typedef struct {
    logic       owner;
    logic [W:0] res;
    logic       err;
  } exp_t;

  exp_t sbQ[$];
  int   ackLog[$];
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   cyc = 0;

  // Monitor bookkeeping (written by the monitor only)
  int ack1Count = 0, startCount = 0, addRstCount = 0, doneCount = 0;
  int addRstCyc = 0, doneCyc = 0;

  // Core-model controls (written by the main process only)
  int coreDelay = 4;
  bit coreNever = 0;
  int straySeq = 0;

  task automatic checkEq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Behavioural adder core: done pulse coreDelay cycles after start is seen.
  initial begin
    int   cnt;
    bit   pending;
    int   strayDone;
    logic [W:0] resHold;
    cnt = 0; pending = 0; strayDone = 0; resHold = '0;
    iAddDone = 1'b0;
    iAddRes  = '0;
    forever begin
      @(posedge iClk);
      #1;
      iAddDone = 1'b0;
      if (iRst || oAddRst) begin
        pending = 0;
      end else if (pending) begin
        if (cnt <= 1) begin
          iAddDone = 1'b1;
          iAddRes  = resHold;
          pending  = 0;
        end else begin
          cnt--;
        end
      end
      if (oAddStart && !iRst && !coreNever) begin
        pending = 1;
        cnt     = coreDelay;
        resHold = {1'b0, oAddOpA} + {1'b0, oAddOpB};
      end
      if (straySeq != strayDone) begin
        iAddDone  = 1'b1;
        iAddRes   = 513'h77;
        strayDone = straySeq;
      end
    end
  end

  // Output monitor and scoreboard pop.
  initial forever begin
    exp_t e;
    @(negedge iClk);
    if (oAck0) ackLog.push_back(0);
    if (oAck1) begin ack1Count++; ackLog.push_back(1); end
    if (oAddStart) startCount++;
    if (oAddRst) begin addRstCount++; addRstCyc = cyc; end
    if (oDone0 || oDone1) begin
      doneCount++;
      doneCyc = cyc;
      $display("txn %0d: cycle=%0d done0=%0d done1=%0d err0=%0d err1=%0d res=%h",
               doneCount, cyc, oDone0, oDone1, oErr0, oErr1, oRes);
      if (sbQ.size() == 0) begin
        checkEq("unexpectedDone", {oDone1, oDone0}, 0);
      end else begin
        e = sbQ.pop_front();
        checkEq("doneOwner", {oDone1, oDone0}, e.owner ? 2'b10 : 2'b01);
        checkEq("result", oRes, e.res);
        checkEq("errFlag", e.owner ? oErr1 : oErr0, e.err);
        checkEq("errOther", e.owner ? oErr0 : oErr1, 0);
      end
    end else if (oErr0 || oErr1) begin
      checkEq("errWithoutDone", {oErr1, oErr0}, 0);
    end
  end

  task automatic pushExp(input logic owner, input logic [W:0] res, input logic err);
    exp_t e;
    e.owner = owner; e.res = res; e.err = err;
    sbQ.push_back(e);
  endtask

  task automatic waitAck(output int ackCyc);
    bit ok;
    ok = 0;
    ackCyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iClk);
      if (oAck0 || oAck1) begin
        ok = 1;
        ackCyc = cyc;
        break;
      end
    end
    checkEq("ackSeen", ok, 1);
  endtask

  task automatic drain(input int maxCyc);
    for (int i = 0; i < maxCyc && sbQ.size() != 0; i++) @(posedge iClk);
    checkEq("drain", sbQ.size(), 0);
    sbQ.delete();
    @(negedge iClk);
  endtask

  task automatic doReset();
    @(negedge iClk);
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  initial begin
    int t0, aCyc, base, baseRst, n, bad, logStart;
    logic [W:0] big;
    big = '0;
    big[W] = 1'b1;
    iRst = 1'b1;
    iReq0 = 0; iReq1 = 0;
    iOpA0 = '0; iOpB0 = '0; iOpA1 = '0; iOpB1 = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);

    // Reset state
    checkEq("rstBusy", oBusy, 0);
    checkEq("rstRes", oRes, 0);
    checkEq("rstOpA", oAddOpA, 0);
    checkEq("rstPulses", {oAck0, oAck1, oDone0, oDone1, oErr0, oErr1, oAddStart, oAddRst}, 0);
    iRst = 1'b0;
    @(negedge iClk);

    // 1: single request, core done 18 cycles after start
    iReq0 = 1; iOpA0 = 5; iOpB0 = 3; coreDelay = 18;
    pushExp(1'b0, 8, 1'b0);
    t0 = cyc;
    waitAck(aCyc);
    checkEq("ackLatency", aCyc - t0, 1);
    checkEq("ack0", {oAck1, oAck0}, 2'b01);
    checkEq("startWithAck", oAddStart, 1);
    iReq0 = 0;
    drain(100);
    checkEq("doneLatency", doneCyc - t0, 21);
    checkEq("ack1Never", ack1Count, 0);
    checkEq("startCount", startCount, 1);

    // 2: simultaneous requests after reset, alternation 0,1,0,1
    doReset();
    @(negedge iClk);
    iOpA0 = 1; iOpB0 = 1; iOpA1 = '1; iOpB1 = 1; coreDelay = 5;
    for (int k = 0; k < 4; k++) pushExp(k[0], k[0] ? big : 2, 1'b0);
    logStart = ackLog.size();
    iReq0 = 1; iReq1 = 1;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge iClk);
      if (oAck0 || oAck1) n++;
    end
    iReq0 = 0; iReq1 = 0;
    checkEq("fourAcks", n, 4);
    drain(200);
    checkEq("ackLogSize", ackLog.size() - logStart, 4);
    for (int k = 0; k < 4 && logStart + k < ackLog.size(); k++)
      checkEq("ackOrder", ackLog[logStart + k], k % 2);

    // 3: timeout, then a normal operation
    coreNever = 1;
    baseRst = addRstCount;
    iReq0 = 1; iOpA0 = 7; iOpB0 = 9;
    pushExp(1'b0, big, 1'b1);
    waitAck(aCyc);
    iReq0 = 0;
    drain(200);
    checkEq("abortCount", addRstCount - baseRst, 1);
    checkEq("abortLatency", addRstCyc - aCyc, T + 1);
    checkEq("doneAfterAbort", doneCyc - addRstCyc, 2);
    coreNever = 0; coreDelay = 3;
    iReq0 = 1;
    pushExp(1'b0, 16, 1'b0);
    waitAck(aCyc);
    iReq0 = 0;
    drain(100);

    // 4: done arrives on the final WAIT cycle
    coreDelay = T;
    baseRst = addRstCount;
    iReq1 = 1; iOpA1 = 'h1234; iOpB1 = 1;
    pushExp(1'b1, 'h1235, 1'b0);
    waitAck(aCyc);
    iReq1 = 0;
    drain(200);
    checkEq("noAbort", addRstCount - baseRst, 0);
    checkEq("coincideLatency", doneCyc - aCyc, T + 2);

    // 5: operand stability after ack
    coreDelay = 10;
    iReq0 = 1; iOpA0 = 'hAAAA; iOpB0 = 'h5555;
    pushExp(1'b0, 'hFFFF, 1'b0);
    waitAck(aCyc);
    iOpA0 = 'h1111; iOpB0 = 'h2222; iReq0 = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge iClk);
      if (!oBusy) break;
      if (oAddOpA !== W'('hAAAA) || oAddOpB !== W'('h5555)) bad++;
    end
    checkEq("opStable", bad, 0);
    drain(50);

    // 6: asynchronous reset mid-WAIT, stray done afterwards
    coreDelay = 30;
    base = doneCount;
    iReq0 = 1; iOpA0 = 'h42; iOpB0 = 1;
    waitAck(aCyc);
    iReq0 = 0;
    repeat (5) @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    checkEq("asyncRstBusy", oBusy, 0);
    checkEq("asyncRstRes", oRes, 0);
    checkEq("asyncRstOpA", oAddOpA, 0);
    checkEq("asyncRstPulses", {oAck0, oAck1, oDone0, oDone1, oErr0, oErr1, oAddStart, oAddRst}, 0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    straySeq++;
    repeat (10) @(negedge iClk);
    checkEq("strayRes", oRes, 0);
    checkEq("strayBusy", oBusy, 0);
    checkEq("strayNoDone", doneCount - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
